// File: rtl/qiangda_pkg.sv
// qiangda_pkg: shared constants for the quiz-buzzer input conditioning stage
package qiangda_pkg;
    localparam int CLK_HZ     = 100000;
    localparam int DEB_MS     = 20;
    localparam int DEB_CYCLES = CLK_HZ / 1000 * DEB_MS;
    localparam int DIV_HALF   = 50000;
    localparam int NUM_KEYS   = 4;
    localparam int KEY1       = 0;
    localparam int KEY2       = 1;
    localparam int KEY3       = 2;
    localparam int KEY4       = 3;
endpackage

// File: rtl/qiangda_debounce_ch.sv
// qiangda_debounce_ch: two-flop synchroniser, stability-count debounce and falling-edge pulse for one active-low button
module qiangda_debounce_ch #(
    parameter int DEB_CYCLES = qiangda_pkg::DEB_CYCLES
) (
    input  logic clk100khz,
    input  logic reset,
    input  logic raw_n,
    output logic db_n,
    output logic fall_pulse
);
    localparam int CW = $clog2(DEB_CYCLES);
    logic s1_q, s2_q, db_q, db_d, pulse_q, pulse_d, accept;
    logic [CW-1:0] cnt_q, cnt_d;
    always_comb begin
        accept  = s2_q != db_q && cnt_q == CW'(DEB_CYCLES - 1);
        cnt_d   = s2_q == db_q || accept ? '0 : cnt_q + 1'b1;
        db_d    = accept ? s2_q : db_q;
        pulse_d = accept && db_q;
    end
    always_ff @(posedge clk100khz) begin
        if (reset) begin
            s1_q    <= 1'b1;
            s2_q    <= 1'b1;
            db_q    <= 1'b1;
            pulse_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            s1_q    <= raw_n;
            s2_q    <= s1_q;
            db_q    <= db_d;
            pulse_q <= pulse_d;
            cnt_q   <= cnt_d;
        end
    end
    assign db_n       = db_q;
    assign fall_pulse = pulse_q;
endmodule

// File: rtl/qiangda_input_cond.sv
// qiangda_input_cond: debounced buttons, press pulses and a 1 Hz clock/tick for the quiz-buzzer controller
module qiangda_input_cond
    import qiangda_pkg::*;
#(
    parameter int DEB_CYCLES = qiangda_pkg::DEB_CYCLES,
    parameter int DIV_HALF   = qiangda_pkg::DIV_HALF
) (
    input  logic                clk100khz,
    input  logic                reset,
    input  logic [NUM_KEYS-1:0] key_n_raw,
    input  logic                clr_n_raw,
    input  logic                div_sync,
    output logic [NUM_KEYS-1:0] key_n_db,
    output logic [NUM_KEYS-1:0] key_press,
    output logic                clr_n_db,
    output logic                clk1hz,
    output logic                tick1hz
);
    localparam int DW = DIV_HALF > 1 ? $clog2(DIV_HALF) : 1;
    for (genvar k = 0; k < NUM_KEYS; k++) begin : g_key
        qiangda_debounce_ch #(.DEB_CYCLES(DEB_CYCLES)) u_key (
            .clk100khz (clk100khz),
            .reset     (reset),
            .raw_n     (key_n_raw[k]),
            .db_n      (key_n_db[k]),
            .fall_pulse(key_press[k])
        );
    end
    qiangda_debounce_ch #(.DEB_CYCLES(DEB_CYCLES)) u_clr (
        .clk100khz (clk100khz),
        .reset     (reset),
        .raw_n     (clr_n_raw),
        .db_n      (clr_n_db),
        .fall_pulse()
    );
    logic [DW-1:0] div_q, div_d;
    logic clk1hz_q, clk1hz_d, tick_q, tick_d, wrap;
    always_comb begin
        wrap     = div_q == DW'(DIV_HALF - 1);
        div_d    = div_sync || wrap ? '0 : div_q + 1'b1;
        clk1hz_d = div_sync ? 1'b0 : clk1hz_q ^ wrap;
        tick_d   = !div_sync && wrap && !clk1hz_q;
    end
    always_ff @(posedge clk100khz) begin
        if (reset) begin
            div_q    <= '0;
            clk1hz_q <= 1'b0;
            tick_q   <= 1'b0;
        end else begin
            div_q    <= div_d;
            clk1hz_q <= clk1hz_d;
            tick_q   <= tick_d;
        end
    end
    assign clk1hz  = clk1hz_q;
    assign tick1hz = tick_q;
endmodule

// File: tb/tb_qiangda_input_cond.sv
// tb_qiangda_input_cond: directed and randomized checks of debounce, press pulses and the 1 Hz divider
module tb_qiangda_input_cond;
    import qiangda_pkg::*;
    localparam int DEB = 4;
    localparam int DH  = 5;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] key_n_raw = 4'hF;
    logic       clr_n_raw = 1'b1;
    logic       div_sync = 1'b0;
    logic [3:0] key_n_db, key_press;
    logic       clr_n_db, clk1hz, tick1hz;
    int         n_cmp = 0;
    int         n_err = 0;

    qiangda_input_cond #(.DEB_CYCLES(DEB), .DIV_HALF(DH)) dut (
        .clk100khz(clk),
        .reset    (reset),
        .key_n_raw(key_n_raw),
        .clr_n_raw(clr_n_raw),
        .div_sync (div_sync),
        .key_n_db (key_n_db),
        .key_press(key_press),
        .clr_n_db (clr_n_db),
        .clk1hz   (clk1hz),
        .tick1hz  (tick1hz)
    );

    always #5 clk = ~clk;

    // Reference: a level is accepted once the two-edge-delayed raw value has
    // disagreed with the accepted level for DEB edges in a row; the 1 Hz
    // outputs are pure arithmetic on edges elapsed since reset/div_sync.
    logic [4:0] m_dly1, m_dly2, m_db;
    logic [3:0] m_press;
    int         m_run[5];
    int         m_k;
    always @(posedge clk) begin
        if (reset) begin
            m_dly1 = '1; m_dly2 = '1; m_db = '1; m_press = '0; m_k = 0;
            for (int c = 0; c < 5; c++) m_run[c] = 0;
        end else begin
            m_press = '0;
            for (int c = 0; c < 5; c++) begin
                m_run[c] = (m_dly2[c] != m_db[c]) ? m_run[c] + 1 : 0;
                if (m_run[c] == DEB) begin
                    m_db[c] = m_dly2[c];
                    m_run[c] = 0;
                    if (c < 4 && !m_db[c]) m_press[c] = 1'b1;
                end
            end
            m_dly2 = m_dly1;
            m_dly1 = {clr_n_raw, key_n_raw};
            m_k = div_sync ? 0 : m_k + 1;
        end
    end
    wire exp_clk  = ((m_k / DH) % 2) == 1;
    wire exp_tick = m_k > 0 && (m_k % (2 * DH)) == DH;

    task automatic test_reset();
        reset = 1'b1; key_n_raw = 4'($urandom); clr_n_raw = 1'($urandom); div_sync = 1'($urandom);
        repeat (3) @(negedge clk);
        n_cmp++;
        if (key_n_db !== 4'hF || clr_n_db !== 1'b1 || key_press !== 4'h0 || clk1hz !== 1'b0 || tick1hz !== 1'b0) begin
            n_err++;
            $display("FAIL reset_values: db=%h clr=%b press=%h clk=%b tick=%b want F 1 0 0 0", key_n_db, clr_n_db, key_press, clk1hz, tick1hz);
        end
        reset = 1'b0; key_n_raw = 4'hF; clr_n_raw = 1'b1; div_sync = 1'b0;
        for (int n = 1; n <= 50; n++) begin
            @(negedge clk);
            n_cmp++;
            if (key_n_db !== 4'hF || clr_n_db !== 1'b1 || key_press !== 4'h0 || clk1hz !== exp_clk || tick1hz !== exp_tick) begin
                n_err++;
                $display("FAIL idle n=%0d: db=%h clr=%b press=%h clk=%b tick=%b want F 1 0 %b %b", n, key_n_db, clr_n_db, key_press, clk1hz, tick1hz, exp_clk, exp_tick);
            end
        end
    endtask

    task automatic test_stable_press();
        key_n_raw[KEY3] = 1'b0;
        for (int n = 1; n <= 10; n++) begin
            @(negedge clk);
            n_cmp++;
            if (key_n_db !== (n >= 6 ? 4'b1011 : 4'b1111) || key_press !== (n == 6 ? 4'b0100 : 4'b0000)) begin
                n_err++;
                $display("FAIL press_key3 n=%0d: db=%b press=%b", n, key_n_db, key_press);
            end
        end
        key_n_raw[KEY3] = 1'b1;
        for (int n = 1; n <= 10; n++) begin
            @(negedge clk);
            n_cmp++;
            if (key_n_db !== (n >= 6 ? 4'b1111 : 4'b1011) || key_press !== 4'b0000) begin
                n_err++;
                $display("FAIL release_key3 n=%0d: db=%b press=%b", n, key_n_db, key_press);
            end
        end
    endtask

    task automatic test_bounce();
        for (int n = 0; n < 30; n++) begin
            if (n < 20 && n % 2 == 0) key_n_raw[KEY1] = ~key_n_raw[KEY1];
            if (n == 20) key_n_raw[KEY1] = 1'b1;
            @(negedge clk);
            n_cmp++;
            if (key_n_db[KEY1] !== 1'b1 || key_press[KEY1] !== 1'b0) begin
                n_err++;
                $display("FAIL bounce_key1 n=%0d: db=%b press=%b want 1 0", n, key_n_db[KEY1], key_press[KEY1]);
            end
        end
    endtask

    task automatic test_simultaneous();
        key_n_raw[KEY2] = 1'b0; key_n_raw[KEY4] = 1'b0;
        for (int n = 1; n <= 9; n++) begin
            @(negedge clk);
            n_cmp++;
            if (key_n_db !== (n >= 6 ? 4'b0101 : 4'b1111) || key_press !== (n == 6 ? 4'b1010 : 4'b0000)) begin
                n_err++;
                $display("FAIL simultaneous n=%0d: db=%b press=%b", n, key_n_db, key_press);
            end
        end
        key_n_raw = 4'hF;
        repeat (10) @(negedge clk);
    endtask

    task automatic test_divider();
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        for (int n = 1; n <= 30; n++) begin
            @(negedge clk);
            n_cmp++;
            if (clk1hz !== 1'((n / 5) % 2) || tick1hz !== (n == 5 || n == 15 || n == 25)) begin
                n_err++;
                $display("FAIL divider edge=%0d: clk=%b tick=%b", n, clk1hz, tick1hz);
            end
        end
    endtask

    task automatic test_div_sync();
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        repeat (6) @(negedge clk);
        n_cmp++;
        if (clk1hz !== 1'b1) begin
            n_err++;
            $display("FAIL pre_sync edge=6: clk=%b want 1", clk1hz);
        end
        div_sync = 1'b1;
        @(negedge clk);
        div_sync = 1'b0;
        n_cmp++;
        if (clk1hz !== 1'b0 || tick1hz !== 1'b0) begin
            n_err++;
            $display("FAIL sync edge=7: clk=%b tick=%b want 0 0", clk1hz, tick1hz);
        end
        for (int n = 8; n <= 24; n++) begin
            @(negedge clk);
            n_cmp++;
            if (clk1hz !== 1'(((n - 7) / 5) % 2) || tick1hz !== (n == 12 || n == 22)) begin
                n_err++;
                $display("FAIL post_sync edge=%0d: clk=%b tick=%b", n, clk1hz, tick1hz);
            end
        end
    endtask

    task automatic test_reset_mid_debounce();
        key_n_raw[KEY4] = 1'b0;
        repeat (5) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        n_cmp++;
        if (key_n_db !== 4'hF || key_press !== 4'h0) begin
            n_err++;
            $display("FAIL reset_mid_deb: db=%b press=%b want 1111 0000", key_n_db, key_press);
        end
        for (int m = 1; m <= 8; m++) begin
            @(negedge clk);
            n_cmp++;
            if (key_n_db !== (m >= 6 ? 4'b0111 : 4'b1111) || key_press !== (m == 6 ? 4'b1000 : 4'b0000)) begin
                n_err++;
                $display("FAIL restart_key4 m=%0d: db=%b press=%b", m, key_n_db, key_press);
            end
        end
        key_n_raw = 4'hF;
        repeat (10) @(negedge clk);
    endtask

    task automatic test_random();
        for (int n = 0; n < 1500; n++) begin
            if ($urandom_range(0, 7) == 0) begin
                int c;
                c = $urandom_range(0, 4);
                if (c == 4) clr_n_raw = ~clr_n_raw;
                else key_n_raw[c] = ~key_n_raw[c];
            end
            div_sync = $urandom_range(0, 39) == 0;
            reset = $urandom_range(0, 199) == 0;
            @(negedge clk);
            n_cmp++;
            if (key_n_db !== m_db[3:0] || clr_n_db !== m_db[4] || key_press !== m_press || clk1hz !== exp_clk || tick1hz !== exp_tick) begin
                n_err++;
                $display("FAIL random n=%0d: db=%b clr=%b press=%b clk=%b tick=%b want %b %b %b %b %b", n, key_n_db, clr_n_db, key_press, clk1hz, tick1hz, m_db[3:0], m_db[4], m_press, exp_clk, exp_tick);
            end
        end
        reset = 1'b0; div_sync = 1'b0; key_n_raw = 4'hF; clr_n_raw = 1'b1;
        repeat (10) @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_stable_press();
        test_bounce();
        test_simultaneous();
        test_divider();
        test_div_sync();
        test_reset_mid_debounce();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
